// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag definitions for the sequential ALU.
// Encodings are fixed so that software and legacy blocks can decode them directly.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic greater;
    logic lesser;
    logic equal;
    logic zero;
    logic carry;
    logic err;
  } alu_flags_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: valid/ready request side, valid/ready result side.
// master = requester/consumer, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [3:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             greater;
  logic             lesser;
  logic             equal;
  logic             zero;
  logic             carry;
  logic             err;

  modport master (
    output in_valid, in_A, in_B, control, out_ready,
    input  in_ready, out_valid, out, greater, lesser, equal, zero, carry, err
  );

  modport slave (
    input  in_valid, in_A, in_B, control, out_ready,
    output in_ready, out_valid, out, greater, lesser, equal, zero, carry, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of the unsigned product.
// Latency: busy for WIDTH cycles after start; done marks the final iteration cycle.
// No backpressure: caller must hold off start while busy.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // product is the accumulator including the iteration in progress, so the
  // caller can capture it on the same edge that retires the last bit
  assign product = acc_nxt;
  assign done    = busy && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic/shifts in one cycle, MUL via iterative multiplier.
// Latency 1 cycle (MUL: WIDTH+1); result held while out_ready is low, new request accepted on drain.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of two and at least 8");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] out_q;
  alu_flags_t       flags_q;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] res;
  alu_flags_t       res_flags;

  // DONE drains and refills in the same cycle when the consumer is ready
  assign bus.in_ready  = !mul_busy &&
                         ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign mul_start     = accept && (bus.control == OP_MUL);

  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = out_q;
  assign bus.greater   = flags_q.greater;
  assign bus.lesser    = flags_q.lesser;
  assign bus.equal     = flags_q.equal;
  assign bus.zero      = flags_q.zero;
  assign bus.carry     = flags_q.carry;
  assign bus.err       = flags_q.err;

  assign shamt = bus.in_B[SHW-1:0];

  always_comb begin
    add_full          = {1'b0, bus.in_A} + {1'b0, bus.in_B};
    res               = '0;
    res_flags         = '0;
    res_flags.greater = bus.in_A >  bus.in_B;
    res_flags.lesser  = bus.in_A <  bus.in_B;
    res_flags.equal   = bus.in_A == bus.in_B;
    case (bus.control)
      OP_ADD: begin
        res             = add_full[WIDTH-1:0];
        res_flags.carry = add_full[WIDTH];
      end
      OP_SUB: begin
        res             = bus.in_A - bus.in_B;
        res_flags.carry = bus.in_A < bus.in_B;
      end
      OP_AND: res = bus.in_A & bus.in_B;
      OP_OR:  res = bus.in_A | bus.in_B;
      OP_XOR: res = bus.in_A ^ bus.in_B;
      OP_SHL: res = bus.in_A << shamt;
      OP_SHR: res = bus.in_A >> shamt;
      OP_SRA: res = $unsigned($signed(bus.in_A) >>> shamt);
      OP_MUL: res = '0;
      default: res_flags.err = 1'b1;
    endcase
    // MUL zero flag is resolved when the product lands
    res_flags.zero = (res == '0) && (bus.control != OP_MUL);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (bus.control == OP_MUL) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_nxt = (bus.control == OP_MUL) ? ST_BUSY : ST_DONE;
        end else if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_q   <= res;
        flags_q <= res_flags;
        flags_q.err <= !op_is_legal(bus.control);
      end else if ((state == ST_BUSY) && mul_done) begin
        out_q        <= mul_product;
        flags_q.zero <= (mul_product == '0);
      end
    end
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.in_A),
    .b       (bus.in_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops against an arithmetic model.
// Main instance is WIDTH=8; a WIDTH=64 instance covers the full-width carry case.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(64)) if64 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit values
  function automatic void model(input int op, input int a, input int b,
                                output int r, output bit c, output bit e);
    int s;
    int sa;
    s = b % 8;
    c = 1'b0;
    e = 1'b0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (1 << s)) % 256;
      6: r = a / (1 << s);
      7: begin sa = (a >= 128) ? a - 256 : a; r = (sa >>> s) & 255; end
      8: r = (a * b) % 256;
      default: begin r = 0; e = 1'b1; end
    endcase
  endfunction

  task automatic check_flags8(input string tag, input int a, input int b,
                              input int r, input bit c, input bit e);
    chk({tag, "_out"},   64'(if8.out),     64'(r));
    chk({tag, "_carry"}, 64'(if8.carry),   64'(c));
    chk({tag, "_err"},   64'(if8.err),     64'(e));
    chk({tag, "_zero"},  64'(if8.zero),    64'(r == 0));
    chk({tag, "_gt"},    64'(if8.greater), 64'(a > b));
    chk({tag, "_lt"},    64'(if8.lesser),  64'(a < b));
    chk({tag, "_eq"},    64'(if8.equal),   64'(a == b));
  endtask

  // One complete transaction from IDLE: accept, wait for result, stall, drain
  task automatic do_op(input string tag, input int op, input int a, input int b, input int stall);
    int r;
    bit c;
    bit e;
    int cyc;
    int lat;
    model(op, a, b, r, c, e);
    lat = (op == 8) ? 9 : 1;
    if8.out_ready = 1'b0;
    if8.in_valid  = 1'b1;
    if8.control   = 4'(op);
    if8.in_A      = 8'(a);
    if8.in_B      = 8'(b);
    chk({tag, "_in_ready"}, 64'(if8.in_ready), 64'd1);
    tick();
    // scramble inputs after acceptance; they must be ignored
    if8.in_valid = 1'($urandom_range(0, 1));
    if8.control  = 4'($urandom);
    if8.in_A     = 8'($urandom);
    if8.in_B     = 8'($urandom);
    cyc = 1;
    while (!if8.out_valid && cyc < 30) begin
      chk({tag, "_busy_rdy"}, 64'(if8.in_ready), 64'd0);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_flags8(tag, a, b, r, c, e);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_vld"}, 64'(if8.out_valid), 64'd1);
      chk({tag, "_hold_out"}, 64'(if8.out),       64'(r));
      chk({tag, "_hold_cy"},  64'(if8.carry),     64'(c));
      chk({tag, "_hold_rdy"}, 64'(if8.in_ready),  64'd0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(if8.out_valid), 64'd0);
  endtask

  initial begin
    int op;
    if8.in_valid   = 1'b0;
    if8.in_A       = '0;
    if8.in_B       = '0;
    if8.control    = '0;
    if8.out_ready  = 1'b0;
    if64.in_valid  = 1'b0;
    if64.in_A      = '0;
    if64.in_B      = '0;
    if64.control   = '0;
    if64.out_ready = 1'b0;

    repeat (3) tick();
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_out",       64'(if8.out),       64'd0);
    chk("rst_flags",     64'({if8.greater, if8.lesser, if8.equal, if8.zero, if8.carry, if8.err}), 64'd0);
    rst = 1'b0;
    chk("rst_in_ready",  64'(if8.in_ready),  64'd1);
    tick();

    // full-width add wraps to zero with carry
    if64.in_valid = 1'b1;
    if64.control  = 4'd0;
    if64.in_A     = 64'hFFFF_FFFF_FFFF_FFFF;
    if64.in_B     = 64'd1;
    tick();
    if64.in_valid = 1'b0;
    chk("w64_valid", 64'(if64.out_valid), 64'd1);
    chk("w64_out",   if64.out,            64'd0);
    chk("w64_carry", 64'(if64.carry),     64'd1);
    chk("w64_zero",  64'(if64.zero),      64'd1);
    chk("w64_gt",    64'(if64.greater),   64'd1);
    if64.out_ready = 1'b1;
    tick();
    chk("w64_drain", 64'(if64.out_valid), 64'd0);

    do_op("sra",  7, 'h90, 3, 0);
    do_op("shr",  6, 'h90, 3, 0);
    do_op("shl",  5, 'h81, 1, 0);
    do_op("shl0", 5, 'h5A, 8, 0);
    do_op("mul",  8, 13, 11, 0);
    do_op("stall", 0, 200, 100, 5);
    do_op("ill",  12, 'h33, 'h44, 0);
    do_op("mulst", 8, 255, 255, 5);

    // back-to-back ADD then SUB with the consumer always ready
    if8.out_ready = 1'b1;
    if8.in_valid  = 1'b1;
    if8.control   = 4'd0;
    if8.in_A      = 8'd3;
    if8.in_B      = 8'd4;
    tick();
    chk("b2b_add_vld", 64'(if8.out_valid), 64'd1);
    chk("b2b_add_out", 64'(if8.out),       64'd7);
    chk("b2b_rdy",     64'(if8.in_ready),  64'd1);
    if8.control = 4'd1;
    if8.in_A    = 8'd5;
    if8.in_B    = 8'd7;
    tick();
    if8.in_valid = 1'b0;
    chk("b2b_sub_vld", 64'(if8.out_valid), 64'd1);
    chk("b2b_sub_out", 64'(if8.out),       64'hFE);
    chk("b2b_sub_cy",  64'(if8.carry),     64'd1);
    chk("b2b_sub_lt",  64'(if8.lesser),    64'd1);
    tick();
    chk("b2b_idle",    64'(if8.out_valid), 64'd0);
    if8.out_ready = 1'b0;

    // reset in the middle of a multiply
    if8.in_valid = 1'b1;
    if8.control  = 4'd8;
    if8.in_A     = 8'd13;
    if8.in_B     = 8'd11;
    tick();
    if8.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mrst_vld",   64'(if8.out_valid), 64'd0);
    chk("mrst_out",   64'(if8.out),       64'd0);
    chk("mrst_flags", 64'({if8.greater, if8.lesser, if8.equal, if8.zero, if8.carry, if8.err}), 64'd0);
    tick();
    rst = 1'b0;
    chk("mrst_rdy",   64'(if8.in_ready),  64'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mrst_no_result", 64'(if8.out_valid), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      do_op("rand", op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width in bits; SHALL be >= 8 and a power of two.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width taken from in_B[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_A  input  WIDTH  operand A.
REQ-008 in_B  input  WIDTH  operand B / shift amount.
REQ-009 control  input  4  opcode.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out  output  WIDTH  result.
REQ-013 greater, lesser, equal  output  1 each  unsigned compare of captured A vs B.
REQ-014 zero, carry, err  output  1 each  out==0; carry/borrow of ADD/SUB; illegal opcode.

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SRA arithmetic, 8 MUL (low WIDTH bits, unsigned); 9-15 illegal.
REQ-016 Shifts SHALL use amount in_B[SHW-1:0]; amount 0 returns A unchanged.
REQ-017 ADD carry = bit WIDTH of A+B; SUB carry = borrow (A<B unsigned); carry SHALL be 0 for all other ops.
REQ-018 Illegal opcode: out=0, err=1, zero=1, completes with single-cycle latency.
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 Transfer accepted when in_valid && in_ready; operands and opcode SHALL be captured on acceptance, later input changes ignored.
REQ-021 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal out_ready in DONE (back-to-back acceptance).
REQ-022 Non-MUL ops: accepted in cycle N -> out_valid=1 with result in cycle N+1 (state DONE).
REQ-023 MUL: IDLE -> BUSY; shift-add over WIDTH iterations, one bit per cycle; accepted in cycle N -> out_valid in cycle N+WIDTH+1.
REQ-024 DONE: out, flags SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE with out_ready: if new request accepted same cycle go to DONE/BUSY per its opcode, else IDLE with out_valid=0 next cycle.
REQ-026 Compare flags SHALL be valid with out_valid and exactly one of greater/lesser/equal SHALL be 1.
REQ-027 in_valid while BUSY SHALL be ignored (not accepted, no effect on running MUL).

Reset
REQ-028 rst asserted at any time, including mid-MUL or DONE stall, SHALL immediately force IDLE, out_valid=0, out=0, all flags 0; in_ready=1 after release.
REQ-029 Partial MUL state SHALL be discarded on reset; no result emitted for the aborted op.

Structure
REQ-030 Opcode encodings, FSM state encodings SHALL live in shared package alu_pkg.
REQ-031 Iterative multiplier SHALL be sub-module alu_mul_iter (start, busy, done, WIDTH-parametrised); rest of datapath inline.

Verification
REQ-032 WIDTH=64: ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> one cycle later out=0, carry=1, zero=1, greater=1.
REQ-033 WIDTH=8: SRA A=0x90, B=3 -> out=0xF2; SHR same -> 0x12; SHL A=0x81,B=1 -> 0x02.
REQ-034 WIDTH=8: MUL A=13, B=11 -> out=0x8F exactly 9 cycles after acceptance; in_ready=0 throughout BUSY.
REQ-035 Back-to-back ADD then SUB(5-7) with out_ready=1 -> results on consecutive cycles, SUB out=0xFE (WIDTH=8), carry=1, lesser=1.
REQ-036 out_ready=0 for 5 cycles after result -> out/flags stable, in_ready=0; rst pulse during MUL mid-run -> out_valid=0, IDLE, no stale result.
REQ-037 control=12 -> out=0, err=1, zero=1, latency 1.
